video_pattern_source: RTL and testbench

Parameterised AXI4-Stream video source: the transmitting end of the pixel stream the keystone correction core consumes. Generates complete frames in the core's packed pixel format, marking start-of-frame and end-of-line. Honours downstream backpressure. Used as an on-chip stimulus for the correction pipeline and as a bring-up pattern source when no camera or HDMI input is attached.

---
 rtl/video_pattern_source_if.sv | 19 +
 rtl/video_pattern_source.sv | 156 +++++++++++++++
 tb/tb_video_pattern_source.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/video_pattern_source_if.sv
// AXI4-Stream style pixel bus carried between the pattern source and its consumer.
// Packed pixel: R [29:22], G [19:12], B [9:2]; tuser = start_of_frame_out, tlast = end_of_line_out.
interface video_pattern_source_if;
   logic [63:0] pixel_stream_out;
   logic        valid_out;
   logic        ready_in;
   logic        start_of_frame_out;
   logic        end_of_line_out;

   modport master (
      output pixel_stream_out, valid_out, start_of_frame_out, end_of_line_out,
      input  ready_in
   );

   modport slave (
      input  pixel_stream_out, valid_out, start_of_frame_out, end_of_line_out,
      output ready_in
   );
endinterface

// File: rtl/video_pattern_source.sv
// Frame generator for the keystone core: solid, ramp, colour-bar and checkerboard patterns
// streamed with SOF/EOL markers, line/frame gaps and full backpressure support.
module video_pattern_source #(
   parameter int WIDTH     = 640,
   parameter int HEIGHT    = 480,
   parameter int LINE_GAP  = 0,
   parameter int FRAME_GAP = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          clock_en,
   input  logic                          enable,
   input  logic [1:0]                    pattern_sel,
   input  logic [23:0]                   solid_color,
   video_pattern_source_if.master        axis,
   output logic                          frame_done,
   output logic [15:0]                   frame_count
);

   localparam int         BAR_W    = WIDTH / 8;
   localparam logic [15:0] X_LAST   = 16'(WIDTH - 1);
   localparam logic [15:0] Y_LAST   = 16'(HEIGHT - 1);
   localparam logic [15:0] BAR_LAST = 16'(BAR_W - 1);
   localparam logic [15:0] LG_LAST  = 16'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);
   localparam logic [15:0] FG_LAST  = 16'(FRAME_GAP - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LINE_GAP, S_FRAME_GAP} state_t;

   state_t      state;
   logic [15:0] x, y, bar_cnt, gap_cnt;
   logic [2:0]  bar_idx, bar_idx_nx;
   logic [15:0] bar_cnt_nx;
   logic [1:0]  pat_q;
   logic [23:0] col_q;
   logic        start, accept;

   logic [63:0] pixel_p0;
   logic        vld_p0, sof_p0, eol_p0, done_p0;

   // Bar colours encode as idx bits: R = ~idx[1], G = ~idx[2], B = ~idx[0].
   function automatic logic [63:0] pixel_fn(input logic [1:0] pat, input logic [23:0] col,
                                            input logic [7:0] xl, input logic y4,
                                            input logic [2:0] bidx);
      logic [7:0] r, g, b;
      case (pat)
         2'd0:    {r, g, b} = col;
         2'd1:    begin r = xl; g = xl; b = xl; end
         2'd2:    begin r = {8{~bidx[1]}}; g = {8{~bidx[2]}}; b = {8{~bidx[0]}}; end
         default: begin r = {8{~(xl[4] ^ y4)}}; g = r; b = r; end
      endcase
      return {34'd0, r, 2'b00, g, 2'b00, b, 2'b00};
   endfunction

   assign start  = enable && ((state == S_IDLE) || (state == S_FRAME_GAP && gap_cnt == FG_LAST));
   assign accept = vld_p0 & axis.ready_in;

   assign bar_cnt_nx = (bar_cnt == BAR_LAST) ? 16'd0 : bar_cnt + 16'd1;
   assign bar_idx_nx = (bar_cnt == BAR_LAST) ? bar_idx + 3'd1 : bar_idx;

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         x           <= '0;
         y           <= '0;
         bar_cnt     <= '0;
         bar_idx     <= '0;
         gap_cnt     <= '0;
         pat_q       <= '0;
         col_q       <= '0;
         pixel_p0    <= '0;
         vld_p0      <= 1'b0;
         sof_p0      <= 1'b0;
         eol_p0      <= 1'b0;
         done_p0     <= 1'b0;
         frame_count <= '0;
      end else if (clock_en) begin
         done_p0 <= 1'b0;
         if (start) begin
            state    <= S_ACTIVE;
            x        <= '0;
            y        <= '0;
            bar_cnt  <= '0;
            bar_idx  <= '0;
            gap_cnt  <= '0;
            pat_q    <= pattern_sel;
            col_q    <= solid_color;
            pixel_p0 <= pixel_fn(pattern_sel, solid_color, 8'd0, 1'b0, 3'd0);
            vld_p0   <= 1'b1;
            sof_p0   <= 1'b1;
            eol_p0   <= 1'b0;
         end else begin
            case (state)
               S_ACTIVE: if (accept) begin
                  sof_p0 <= 1'b0;
                  if (x == X_LAST) begin
                     x       <= '0;
                     bar_cnt <= '0;
                     bar_idx <= '0;
                     eol_p0  <= 1'b0;
                     if (y == Y_LAST) begin
                        y           <= '0;
                        vld_p0      <= 1'b0;
                        done_p0     <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        gap_cnt     <= '0;
                        state       <= S_FRAME_GAP;
                     end else begin
                        y <= y + 16'd1;
                        if (LINE_GAP > 0) begin
                           vld_p0  <= 1'b0;
                           gap_cnt <= '0;
                           state   <= S_LINE_GAP;
                        end else begin
                           pixel_p0 <= pixel_fn(pat_q, col_q, 8'd0, y[4] ^ (y[3:0] == 4'hF), 3'd0);
                        end
                     end
                  end else begin
                     x        <= x + 16'd1;
                     bar_cnt  <= bar_cnt_nx;
                     bar_idx  <= bar_idx_nx;
                     pixel_p0 <= pixel_fn(pat_q, col_q, x[7:0] + 8'd1, y[4], bar_idx_nx);
                     eol_p0   <= ((x + 16'd1) == X_LAST);
                  end
               end
               // Line gap: x/y already point at the first pixel of the next line.
               S_LINE_GAP: begin
                  if (gap_cnt == LG_LAST) begin
                     state    <= S_ACTIVE;
                     gap_cnt  <= '0;
                     vld_p0   <= 1'b1;
                     pixel_p0 <= pixel_fn(pat_q, col_q, x[7:0], y[4], bar_idx);
                  end else begin
                     gap_cnt <= gap_cnt + 16'd1;
                  end
               end
               S_FRAME_GAP: begin
                  if (gap_cnt == FG_LAST) begin
                     state   <= S_IDLE;
                     gap_cnt <= '0;
                  end else begin
                     gap_cnt <= gap_cnt + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign axis.pixel_stream_out   = pixel_p0;
   assign axis.valid_out          = vld_p0;
   assign axis.start_of_frame_out = sof_p0;
   assign axis.end_of_line_out    = eol_p0;
   assign frame_done              = done_p0 & clock_en;

endmodule

// File: tb/tb_video_pattern_source.sv
// Directed/randomised bench for video_pattern_source against a coordinate-level frame model.
module tb_video_pattern_source;
   localparam int W  = 16;
   localparam int H  = 4;
   localparam int LG = 2;
   localparam int FG = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        clock_en = 1'b1;
   logic        enable = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic [23:0] solid_color = 24'd0;
   logic        frame_done;
   logic [15:0] frame_count;

   int checks = 0;
   int errors = 0;

   video_pattern_source_if vif();

   video_pattern_source #(.WIDTH(W), .HEIGHT(H), .LINE_GAP(LG), .FRAME_GAP(FG)) dut (
      .clock       (clock),
      .reset       (reset),
      .clock_en    (clock_en),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .solid_color (solid_color),
      .axis        (vif),
      .frame_done  (frame_done),
      .frame_count (frame_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [63:0] model_pix(input int pat, input logic [23:0] col, input int px, input int py);
      logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      logic [23:0] c;
      case (pat)
         0:       c = col;
         1:       c = {3{8'(px % 256)}};
         2:       c = bars[px / (W / 8)];
         default: c = (((px / 16) % 2) == ((py / 16) % 2)) ? 24'hFFFFFF : 24'h000000;
      endcase
      return (64'(c[23:16]) << 22) | (64'(c[15:8]) << 12) | (64'(c[7:0]) << 2);
   endfunction

   // Consume one frame; chg_beat flips pattern/enable mid-frame, ce_beat inserts a 5-cycle clock_en stall.
   task automatic consume_frame(input int pat, input logic [23:0] col, input bit stall,
                                input int chg_beat, input int ce_beat, input int fc_exp);
      int ex, ey, nacc, gap, cyc, fd;
      bit held, ce_done;
      logic [63:0] hd;
      logic hs, he, hv;
      logic [15:0] hfc;
      ex = 0; ey = 0; nacc = 0; gap = 0; cyc = 0; fd = 0; held = 0; ce_done = 0;
      while (ey < H && cyc < 3000) begin
         if (cyc > 0 && frame_done) fd++;
         if (nacc == ce_beat && !ce_done) begin
            ce_done = 1;
            hv = vif.valid_out; hd = vif.pixel_stream_out;
            hs = vif.start_of_frame_out; he = vif.end_of_line_out; hfc = frame_count;
            clock_en = 1'b0;
            vif.ready_in = 1'b1;
            repeat (5) begin
               step();
               chk("ce_valid", vif.valid_out, hv);
               chk("ce_data", vif.pixel_stream_out, hd);
               chk("ce_sof", vif.start_of_frame_out, hs);
               chk("ce_eol", vif.end_of_line_out, he);
               chk("ce_count", frame_count, hfc);
               chk("ce_done", frame_done, 0);
            end
            clock_en = 1'b1;
         end
         if (held) begin
            chk("hold_valid", vif.valid_out, 1);
            chk("hold_data", vif.pixel_stream_out, hd);
            chk("hold_sof", vif.start_of_frame_out, hs);
            chk("hold_eol", vif.end_of_line_out, he);
         end
         if (nacc == chg_beat) begin
            pattern_sel = 2'd3;
            enable = 1'b0;
         end
         vif.ready_in = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (vif.valid_out) begin
            if (!held && ex == 0 && ey > 0) chk("line_gap", gap, LG);
            gap = 0;
            if (vif.ready_in) begin
               chk("data", vif.pixel_stream_out, model_pix(pat, col, ex, ey));
               chk("sof", vif.start_of_frame_out, (ex == 0 && ey == 0));
               chk("eol", vif.end_of_line_out, (ex == W - 1));
               held = 0;
               nacc++;
               ex++;
               if (ex == W) begin
                  ex = 0;
                  ey++;
               end
            end else begin
               held = 1;
               hd = vif.pixel_stream_out;
               hs = vif.start_of_frame_out;
               he = vif.end_of_line_out;
            end
         end else begin
            gap++;
            held = 0;
         end
         step();
         cyc++;
      end
      chk("frame_timeout", (cyc < 3000), 1);
      chk("frame_done_pulse", frame_done, 1);
      chk("frame_done_early", fd, 0);
      chk("frame_count", frame_count, fc_exp);
   endtask

   initial begin
      int g, nv;
      logic [23:0] col;
      vif.ready_in = 1'b0;

      // Reset and idle
      step(); step();
      chk("rst_valid", vif.valid_out, 0);
      chk("rst_data", vif.pixel_stream_out, 0);
      chk("rst_sof", vif.start_of_frame_out, 0);
      chk("rst_eol", vif.end_of_line_out, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_count", frame_count, 0);
      reset = 1'b0;
      repeat (20) begin
         step();
         chk("idle_valid", vif.valid_out, 0);
         chk("idle_data", vif.pixel_stream_out, 0);
         chk("idle_count", frame_count, 0);
      end

      // Ramp with ready high
      pattern_sel = 2'd1;
      enable = 1'b1;
      step();
      chk("first_valid", vif.valid_out, 1);
      chk("first_sof", vif.start_of_frame_out, 1);
      chk("first_data", vif.pixel_stream_out, 0);
      consume_frame(1, 24'd0, 0, -1, -1, 1);
      g = 0;
      while (!vif.valid_out && g < 20) begin
         g++;
         step();
      end
      chk("frame_gap", g, FG);
      chk("next_sof", vif.start_of_frame_out, 1);

      // Backpressure over three frames
      consume_frame(1, 24'd0, 1, -1, -1, 2);
      consume_frame(1, 24'd0, 1, -1, -1, 3);
      consume_frame(1, 24'd0, 1, -1, -1, 4);
      enable = 1'b0;
      repeat (FG + 2) step();
      chk("idle_after_bp", vif.valid_out, 0);

      // Colour bars, checkerboard, solid
      pattern_sel = 2'd2;
      enable = 1'b1;
      step();
      chk("bars_sof", vif.start_of_frame_out, 1);
      consume_frame(2, 24'd0, 0, -1, -1, 5);
      pattern_sel = 2'd3;
      consume_frame(3, 24'd0, 1, -1, -1, 6);
      col = 24'($urandom);
      solid_color = col;
      pattern_sel = 2'd0;
      consume_frame(0, col, 1, -1, -1, 7);

      // Mid-frame pattern/enable change
      pattern_sel = 2'd1;
      solid_color = 24'($urandom);
      consume_frame(1, col, 0, 20, -1, 8);
      nv = 0;
      repeat (40) begin
         step();
         if (vif.valid_out) nv++;
      end
      chk("stays_idle", nv, 0);
      chk("count_after_change", frame_count, 8);

      // Reset during a stalled beat
      vif.ready_in = 1'b0;
      pattern_sel = 2'd1;
      enable = 1'b1;
      step();
      chk("stall_valid", vif.valid_out, 1);
      step(); step();
      chk("stall_still_valid", vif.valid_out, 1);
      reset = 1'b1;
      enable = 1'b0;
      step();
      chk("rst2_valid", vif.valid_out, 0);
      chk("rst2_count", frame_count, 0);
      chk("rst2_sof", vif.start_of_frame_out, 0);
      reset = 1'b0;
      step();
      chk("rst2_after_valid", vif.valid_out, 0);
      enable = 1'b1;
      step();
      chk("reen_valid", vif.valid_out, 1);
      chk("reen_sof", vif.start_of_frame_out, 1);
      chk("reen_data", vif.pixel_stream_out, 0);
      consume_frame(1, 24'd0, 0, -1, 5, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
